systolic_feeder: RTL and testbench
==================================

SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, element width of tile entries.
REQ-002 SHALL have parameter ARRAY_SIZE, default 16, systolic array dimension (lanes and tile depth).
REQ-003 SHALL have clk  input  1  clock, all logic rising-edge.
REQ-004 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have clr  input  1  synchronous clear, priority over start.
REQ-006 SHALL have start  input  1  single-cycle request to capture and stream one tile.
REQ-007 SHALL have activated_lane_num  input  5  number of lanes to drive (1..ARRAY_SIZE), sampled with start.
REQ-008 SHALL have zero_point  input  DATA_WIDTH  unsigned input zero point, sampled with start.
REQ-009 SHALL have tile_in  input  [ARRAY_SIZE][ARRAY_SIZE] x DATA_WIDTH  unsigned tile, tile_in[r][k] = lane r, depth index k.
REQ-010 SHALL have feed_data  output  [ARRAY_SIZE] x (DATA_WIDTH+1) signed  per-lane operand to array edge.
REQ-011 SHALL have feed_valid  output  ARRAY_SIZE  per-lane valid qualifier.
REQ-012 SHALL have tile_consumed  output  1  one-cycle pulse: tile_in captured, source may change it.
REQ-013 SHALL have busy  output  1  high from capture until last beat issued.
REQ-014 SHALL have feeding_done  output  1  sticky completion flag.

Function
REQ-015 SHALL implement FSM IDLE -> FEED -> DONE; DONE behaves as IDLE for accepting start.
REQ-016 SHALL, on start in IDLE/DONE, register tile_in, zero_point, N = activated_lane_num (values >ARRAY_SIZE clamp to ARRAY_SIZE), clear feeding_done, set busy, pulse tile_consumed next cycle, enter FEED.
REQ-017 SHALL ignore start while in FEED (no recapture, no tile_consumed pulse).
REQ-018 SHALL, in FEED, run beat counter t = 0..N+ARRAY_SIZE-2, first beat on the cycle after start is sampled.
REQ-019 SHALL drive lane r (r<N) at beat t with feed_valid[r]=1 and feed_data[r] = tile[r][t-r] - zero_point when r <= t <= r+ARRAY_SIZE-1 (diagonal skew of r cycles).
REQ-020 SHALL drive feed_valid[r]=0 and feed_data[r]=0 for r>=N and outside the lane window.
REQ-021 SHALL compute subtraction as zero-extended (DATA_WIDTH+1)-bit signed, no saturation (range -255..255 for 8-bit).
REQ-022 SHALL register feed_data/feed_valid (one flop stage from captured buffer to output).
REQ-023 SHALL, after beat N+ARRAY_SIZE-2, deassert busy, set feeding_done, enter DONE; feeding_done holds until start or clr.
REQ-024 SHALL treat N=0 as no-op: on start, tile_consumed pulses, no valid beats, feeding_done set on the following cycle.
REQ-025 SHALL, on clr (any state, including mid-FEED), return to IDLE within one cycle, zero feed_data, feed_valid, busy, feeding_done, tile_consumed, buffer; start in same cycle as clr ignored.

Reset
REQ-026 SHALL, on rst_n low, asynchronously force IDLE, t=0, buffer=0, feed_data=0, feed_valid=0, tile_consumed=0, busy=0, feeding_done=0.
REQ-027 SHALL resume normal operation on first rising clk after rst_n deasserts; reset mid-FEED discards tile with no further valid beats.

Structure
REQ-028 SHALL place DATA_WIDTH/ARRAY_SIZE defaults and FSM state enum in shared package accel_pkg, reused by output_proc-side blocks.
REQ-029 SHALL keep per-lane skew/subtract logic in one sub-module feeder_lane, instantiated ARRAY_SIZE times; FSM and counter in top.

Verification
REQ-030 Full tile: N=16, zp=0, tile[r][k]=16r+k, start -> lane 0 valid beats 0..15 data 0..15; lane 15 valid beats 15..30 data 240..255; done after beat 30, busy low.
REQ-031 Zero point: N=1, zp=128, tile[0][k]=0 and 255 alternating -> feed_data[0] = -128, 127 alternating; lanes 1..15 valid=0.
REQ-032 Partial lanes: N=4 -> only feed_valid[3:0] ever high, last beat t=18, feeding_done at cycle 20 after start.
REQ-033 Start while busy: second start at beat 5 with different tile -> no tile_consumed pulse, output stream identical to first tile.
REQ-034 clr at beat 7 of N=16 run -> next cycle all feed_valid=0, busy=0, feeding_done=0; subsequent start streams new tile from beat 0.
REQ-035 Async reset mid-FEED and N=0 start -> outputs zero immediately; N=0 gives tile_consumed pulse, no valids, feeding_done next cycle.

Source files
------------

// File: rtl/accel_pkg.sv
// Shared accelerator definitions: default tile geometry, the feeder FSM
// state encoding and a helper that sizes the beat counter.
// No ports; imported by the feeder interface, top and lane modules.
package accel_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int ARRAY_SIZE_DEF = 16;
    localparam int LANE_NUM_W     = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FEED = 2'd1,
        ST_DONE = 2'd2
    } feeder_state_e;

    // The beat counter must reach 2*ARRAY_SIZE-2 and stay unsigned-safe
    // when a lane offset is subtracted from it, hence one spare bit.
    function automatic int beat_cnt_width(input int array_size);
        return $clog2(2 * array_size) + 1;
    endfunction

endpackage

// File: rtl/systolic_feeder_if.sv
// Tile-feeder bus: tile request/capture handshake from the tile source and
// the skewed per-lane operand stream towards the systolic array edge.
//   master : tile source / controller (drives start, lane count, zp, tile)
//   slave  : systolic_feeder (drives feed_data/feed_valid and status)
// feed_data elements are two's-complement (DATA_WIDTH+1)-bit values.
interface systolic_feeder_if
    import accel_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ARRAY_SIZE = ARRAY_SIZE_DEF
) ();

    logic                                             start;
    logic [LANE_NUM_W-1:0]                            activated_lane_num;
    logic [DATA_WIDTH-1:0]                            zero_point;
    logic [ARRAY_SIZE-1:0][ARRAY_SIZE-1:0][DATA_WIDTH-1:0] tile_in;
    logic [ARRAY_SIZE-1:0][DATA_WIDTH:0]              feed_data;
    logic [ARRAY_SIZE-1:0]                            feed_valid;
    logic                                             tile_consumed;
    logic                                             busy;
    logic                                             feeding_done;

    modport master (
        output start, activated_lane_num, zero_point, tile_in,
        input  feed_data, feed_valid, tile_consumed, busy, feeding_done
    );

    modport slave (
        input  start, activated_lane_num, zero_point, tile_in,
        output feed_data, feed_valid, tile_consumed, busy, feeding_done
    );

endinterface

// File: rtl/feeder_lane.sv
// One lane of the systolic feeder: picks element row[t-LANE] while the beat
// counter is inside this lane's diagonal window, subtracts the zero point
// and registers the result.
//   clk, rst_n, clr : clock, async active-low reset, synchronous clear
//   feed_en         : FSM is in FEED
//   beat            : current beat counter t
//   lanes           : number of active lanes N (already clamped)
//   zero_point, row : captured zero point and this lane's captured row
//   data, valid     : registered operand and qualifier for this lane
module feeder_lane
    import accel_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ARRAY_SIZE = ARRAY_SIZE_DEF,
    parameter int CNT_W      = beat_cnt_width(ARRAY_SIZE_DEF),
    parameter int LANE       = 0
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 clr,
    input  logic                                 feed_en,
    input  logic [CNT_W-1:0]                     beat,
    input  logic [LANE_NUM_W-1:0]                lanes,
    input  logic [DATA_WIDTH-1:0]                zero_point,
    input  logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] row,
    output logic [DATA_WIDTH:0]                  data,
    output logic                                 valid
);

    localparam int                    IDX_W    = $clog2(ARRAY_SIZE);
    localparam logic [CNT_W:0]        LANE_OFS = (CNT_W + 1)'(LANE);
    localparam logic [CNT_W:0]        DEPTH    = (CNT_W + 1)'(ARRAY_SIZE);
    localparam logic [LANE_NUM_W-1:0] LANE_ID  = LANE_NUM_W'(LANE);

    logic [CNT_W:0]        offset_s;
    logic                  hit_s;
    logic [DATA_WIDTH-1:0] elem_s;
    logic [DATA_WIDTH:0]   diff_s;

    // Window test and zero-extended subtraction; a set MSB on offset_s means
    // the beat has not yet reached this lane's skew.
    always_comb begin
        offset_s = {1'b0, beat} - LANE_OFS;
        if (feed_en && (LANE_ID < lanes) && !offset_s[CNT_W] && (offset_s < DEPTH)) begin
            hit_s = 1'b1;
        end else begin
            hit_s = 1'b0;
        end
        elem_s = row[offset_s[IDX_W-1:0]];
        diff_s = {1'b0, elem_s} - {1'b0, zero_point};
    end

    // Output register: operand only while inside the window, zero otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (clr) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (hit_s) begin
            data  <= diff_s;
            valid <= 1'b1;
        end else begin
            data  <= '0;
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/systolic_feeder.sv
// Systolic array tile feeder. Captures a tile on start, then streams it into
// the array edge with a diagonal skew of r beats on lane r, subtracting the
// input zero point. FSM IDLE -> FEED -> DONE; DONE accepts start like IDLE.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   clr   : synchronous clear, wins over start
//   bus   : slave side of systolic_feeder_if (request, tile, stream, status)
module systolic_feeder
    import accel_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ARRAY_SIZE = ARRAY_SIZE_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    systolic_feeder_if.slave  bus
);

    localparam int                    CNT_W     = beat_cnt_width(ARRAY_SIZE);
    localparam logic [LANE_NUM_W-1:0] MAX_LANES = LANE_NUM_W'(ARRAY_SIZE);
    localparam logic [CNT_W-1:0]      SKEW_SPAN = CNT_W'(ARRAY_SIZE - 2);

    feeder_state_e                                    state_r;
    logic [CNT_W-1:0]                                 beat_r;
    logic [ARRAY_SIZE-1:0][ARRAY_SIZE-1:0][DATA_WIDTH-1:0] tile_r;
    logic [DATA_WIDTH-1:0]                            zp_r;
    logic [LANE_NUM_W-1:0]                            lanes_r;
    logic                                             consumed_r;
    logic                                             busy_r;
    logic                                             done_r;

    logic [LANE_NUM_W-1:0]                            lanes_s;
    logic [CNT_W-1:0]                                 last_beat_s;
    logic                                             feed_en_s;
    logic [ARRAY_SIZE-1:0][DATA_WIDTH:0]              feed_data_s;
    logic [ARRAY_SIZE-1:0]                            feed_valid_s;

    // Lane-count clamp and last-beat index; N=0 ends on the very first beat.
    always_comb begin
        if (bus.activated_lane_num > MAX_LANES) begin
            lanes_s = MAX_LANES;
        end else begin
            lanes_s = bus.activated_lane_num;
        end
        if (lanes_r == {LANE_NUM_W{1'b0}}) begin
            last_beat_s = '0;
        end else begin
            last_beat_s = CNT_W'(lanes_r) + SKEW_SPAN;
        end
        feed_en_s = (state_r == ST_FEED);
    end

    // Control FSM, beat counter, tile capture and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            beat_r     <= '0;
            tile_r     <= '0;
            zp_r       <= '0;
            lanes_r    <= '0;
            consumed_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else if (clr) begin
            state_r    <= ST_IDLE;
            beat_r     <= '0;
            tile_r     <= '0;
            zp_r       <= '0;
            lanes_r    <= '0;
            consumed_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            consumed_r <= 1'b0;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        tile_r     <= bus.tile_in;
                        zp_r       <= bus.zero_point;
                        lanes_r    <= lanes_s;
                        beat_r     <= '0;
                        consumed_r <= 1'b1;
                        busy_r     <= 1'b1;
                        done_r     <= 1'b0;
                        state_r    <= ST_FEED;
                    end else begin
                        state_r    <= state_r;
                    end
                end
                ST_FEED: begin
                    if (beat_r == last_beat_s) begin
                        beat_r  <= '0;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        beat_r  <= beat_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar r = 0; r < ARRAY_SIZE; r++) begin : g_lane
        feeder_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .ARRAY_SIZE (ARRAY_SIZE),
            .CNT_W      (CNT_W),
            .LANE       (r)
        ) u_lane (
            .clk        (clk),
            .rst_n      (rst_n),
            .clr        (clr),
            .feed_en    (feed_en_s),
            .beat       (beat_r),
            .lanes      (lanes_r),
            .zero_point (zp_r),
            .row        (tile_r[r]),
            .data       (feed_data_s[r]),
            .valid      (feed_valid_s[r])
        );
    end

    assign bus.feed_data     = feed_data_s;
    assign bus.feed_valid    = feed_valid_s;
    assign bus.tile_consumed = consumed_r;
    assign bus.busy          = busy_r;
    assign bus.feeding_done  = done_r;

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder (DATA_WIDTH=8, ARRAY_SIZE=16).
module tb_systolic_feeder;

    typedef logic [15:0][15:0][7:0] tile_t;

    logic clk = 1'b0;
    logic rst_n;
    logic clr;
    int   n_cmp = 0;
    int   n_err = 0;

    systolic_feeder_if #(.DATA_WIDTH(8), .ARRAY_SIZE(16)) bus ();

    systolic_feeder #(.DATA_WIDTH(8), .ARRAY_SIZE(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic tile_t make_tile(input int kind);
        tile_t t;
        for (int r = 0; r < 16; r++) begin
            for (int k = 0; k < 16; k++) begin
                case (kind)
                    0:       t[r][k] = 8'(16 * r + k);
                    1:       t[r][k] = (r == 0) ? ((k % 2 == 0) ? 8'd0 : 8'd255) : 8'(r * 37 + k * 11);
                    2:       t[r][k] = 8'(r * 7 + k * 13 + 5);
                    default: t[r][k] = 8'(255 - (r * 19 + k * 3));
                endcase
            end
        end
        return t;
    endfunction

    function automatic logic [15:0] exp_valid(input int n, input int b);
        logic [15:0] v;
        v = 16'h0000;
        for (int r = 0; r < 16; r++) begin
            if (r < n && b >= r && b <= r + 15) v[r] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [143:0] exp_data(input tile_t tl, input logic [7:0] zp, input int n, input int b);
        logic [143:0] d;
        logic [8:0]   e;
        d = '0;
        for (int r = 0; r < 16; r++) begin
            if (r < n && b >= r && b <= r + 15) begin
                e = {1'b0, tl[r][b - r]} - {1'b0, zp};
                d[r * 9 +: 9] = e;
            end
        end
        return d;
    endfunction

    // Start a tile at the current negedge and check every cycle of the run;
    // optionally raise a second start at cycle inject_c.
    task automatic stream(input string nm, input tile_t tl, input logic [7:0] zp,
                          input logic [4:0] n_raw, input int inject_c, input tile_t alt);
        int n;
        int last;
        n    = (n_raw > 5'd16) ? 16 : int'(n_raw);
        last = (n == 0) ? 0 : n + 14;
        bus.tile_in            = tl;
        bus.zero_point         = zp;
        bus.activated_lane_num = n_raw;
        bus.start              = 1'b1;
        for (int c = 1; c <= last + 4; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (c == 1) bus.tile_in = alt;
            chk($sformatf("%s tc c%0d", nm, c), 144'(bus.tile_consumed), 144'(c == 1));
            chk($sformatf("%s busy c%0d", nm, c), 144'(bus.busy), 144'(c <= last + 1));
            chk($sformatf("%s done c%0d", nm, c), 144'(bus.feeding_done), 144'(c >= last + 2));
            chk($sformatf("%s valid c%0d", nm, c), 144'(bus.feed_valid), 144'(exp_valid(n, c - 2)));
            chk($sformatf("%s data c%0d", nm, c), bus.feed_data, exp_data(tl, zp, n, c - 2));
            if (c == inject_c) begin
                bus.start              = 1'b1;
                bus.activated_lane_num = 5'd3;
                bus.zero_point         = 8'd9;
            end
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, " valid"}, 144'(bus.feed_valid), 144'(16'h0000));
        chk({nm, " data"}, bus.feed_data, 144'h0);
        chk({nm, " busy"}, 144'(bus.busy), 144'(1'b0));
        chk({nm, " done"}, 144'(bus.feeding_done), 144'(1'b0));
        chk({nm, " tc"}, 144'(bus.tile_consumed), 144'(1'b0));
    endtask

    initial begin
        tile_t ta;
        tile_t tb_t;
        tile_t tc_t;
        tile_t td;
        ta   = make_tile(0);
        tb_t = make_tile(1);
        tc_t = make_tile(2);
        td   = make_tile(3);

        rst_n = 1'b0;
        clr   = 1'b0;
        bus.start              = 1'b0;
        bus.activated_lane_num = 5'd0;
        bus.zero_point         = 8'd0;
        bus.tile_in            = '0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Full tile, hand-computed spot values.
        bus.tile_in = ta; bus.zero_point = 8'd0; bus.activated_lane_num = 5'd16; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("full tc c1", 144'(bus.tile_consumed), 144'(1'b1));
        chk("full busy c1", 144'(bus.busy), 144'(1'b1));
        chk("full valid c1", 144'(bus.feed_valid), 144'(16'h0000));
        @(negedge clk);
        chk("full valid beat0", 144'(bus.feed_valid), 144'(16'h0001));
        chk("full lane0 beat0", 144'(bus.feed_data[0]), 144'(9'h000));
        repeat (15) @(negedge clk);
        chk("full valid beat15", 144'(bus.feed_valid), 144'(16'hFFFF));
        chk("full lane0 beat15", 144'(bus.feed_data[0]), 144'(9'h00F));
        chk("full lane15 beat15", 144'(bus.feed_data[15]), 144'(9'h0F0));
        repeat (15) @(negedge clk);
        chk("full valid beat30", 144'(bus.feed_valid), 144'(16'h8000));
        chk("full lane15 beat30", 144'(bus.feed_data[15]), 144'(9'h0FF));
        chk("full busy end", 144'(bus.busy), 144'(1'b0));
        chk("full done end", 144'(bus.feeding_done), 144'(1'b1));
        @(negedge clk);
        chk("full valid after", 144'(bus.feed_valid), 144'(16'h0000));
        chk("full done sticky", 144'(bus.feeding_done), 144'(1'b1));

        // Zero point 128 on one lane, hand-computed.
        bus.tile_in = tb_t; bus.zero_point = 8'd128; bus.activated_lane_num = 5'd1; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("zp tc c1", 144'(bus.tile_consumed), 144'(1'b1));
        chk("zp done cleared", 144'(bus.feeding_done), 144'(1'b0));
        @(negedge clk);
        chk("zp valid beat0", 144'(bus.feed_valid), 144'(16'h0001));
        chk("zp lane0 beat0", 144'(bus.feed_data[0]), 144'(9'h180));
        @(negedge clk);
        chk("zp lane0 beat1", 144'(bus.feed_data[0]), 144'(9'h07F));
        repeat (14) @(negedge clk);
        chk("zp valid beat15", 144'(bus.feed_valid), 144'(16'h0001));
        chk("zp lane0 beat15", 144'(bus.feed_data[0]), 144'(9'h07F));
        chk("zp done", 144'(bus.feeding_done), 144'(1'b1));
        chk("zp busy", 144'(bus.busy), 144'(1'b0));
        @(negedge clk);

        // Cycle-by-cycle runs.
        stream("sweep16", ta, 8'd0, 5'd16, -1, td);
        stream("sweepzp", tb_t, 8'd128, 5'd1, -1, td);
        stream("partial4", tc_t, 8'd77, 5'd4, -1, td);
        stream("restart", ta, 8'd3, 5'd16, 6, td);

        // Synchronous clear at beat 7, with a start in the same cycle.
        bus.tile_in = tb_t; bus.zero_point = 8'd0; bus.activated_lane_num = 5'd16; bus.start = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        chk("clr busy before", 144'(bus.busy), 144'(1'b1));
        clr = 1'b1; bus.start = 1'b1; bus.tile_in = tc_t;
        @(negedge clk);
        clr = 1'b0; bus.start = 1'b0;
        chk_zero("clr");
        @(negedge clk);
        chk_zero("clr idle");
        stream("postclr", tc_t, 8'd200, 5'd31, -1, td);

        // Asynchronous reset in the middle of a run.
        bus.tile_in = ta; bus.zero_point = 8'd0; bus.activated_lane_num = 5'd16; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_zero("async rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_zero("post rst");
        stream("zero_n", td, 8'd5, 5'd0, -1, ta);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
